// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of the single-port 2 KiB byte RAM.
// Define RAM_ARB_RSP_REG_EN to register the read response (2-cycle read latency).
module ram_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic        a_wr,
  input  logic [10:0] a_addr,
  input  logic [7:0]  a_din,
  output logic        a_rsp_valid,
  output logic [7:0]  a_rsp_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic        b_wr,
  input  logic [10:0] b_addr,
  input  logic [7:0]  b_din,
  output logic        b_rsp_valid,
  output logic [7:0]  b_rsp_data,
  output logic [10:0] ram_addr,
  output logic [7:0]  ram_din,
  output logic        ram_wr,
  input  logic [7:0]  ram_dout
);
  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  logic       last_r;
  logic       tag_valid_r;
  logic       tag_owner_r;
  logic       grant_a_s;
  logic       grant_b_s;
  logic       rsp_valid_s;
  logic       rsp_owner_s;
  logic [7:0] rsp_data_s;

  // Round-robin grant; nothing is granted while reset is held
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if (!rst_n) begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end else if (a_valid && b_valid) begin
      grant_a_s = (last_r == OWNER_B);
      grant_b_s = (last_r == OWNER_A);
    end else begin
      grant_a_s = a_valid;
      grant_b_s = b_valid;
    end
  end

  assign a_ready = grant_a_s;
  assign b_ready = grant_b_s;

  // RAM port mux, parked at zero when idle
  always_comb begin
    ram_addr = 11'h000;
    ram_din  = 8'h00;
    ram_wr   = 1'b0;
    if (grant_a_s) begin
      ram_addr = a_addr;
      ram_din  = a_din;
      ram_wr   = a_wr;
    end else if (grant_b_s) begin
      ram_addr = b_addr;
      ram_din  = b_din;
      ram_wr   = b_wr;
    end else begin
      ram_addr = 11'h000;
      ram_din  = 8'h00;
      ram_wr   = 1'b0;
    end
  end

  // Round-robin pointer and one-entry read tag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_r      <= OWNER_B;
      tag_valid_r <= 1'b0;
      tag_owner_r <= OWNER_A;
    end else if (grant_a_s) begin
      last_r      <= OWNER_A;
      tag_valid_r <= ~a_wr;
      tag_owner_r <= OWNER_A;
    end else if (grant_b_s) begin
      last_r      <= OWNER_B;
      tag_valid_r <= ~b_wr;
      tag_owner_r <= OWNER_B;
    end else begin
      last_r      <= last_r;
      tag_valid_r <= 1'b0;
      tag_owner_r <= tag_owner_r;
    end
  end

`ifdef RAM_ARB_RSP_REG_EN
  logic       rsp_valid_r;
  logic       rsp_owner_r;
  logic [7:0] rsp_data_r;

  // Second tag stage plus captured RAM data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_r <= 1'b0;
      rsp_owner_r <= OWNER_A;
      rsp_data_r  <= 8'h00;
    end else begin
      rsp_valid_r <= tag_valid_r;
      rsp_owner_r <= tag_owner_r;
      rsp_data_r  <= tag_valid_r ? ram_dout : 8'h00;
    end
  end

  assign rsp_valid_s = rsp_valid_r & rst_n;
  assign rsp_owner_s = rsp_owner_r;
  assign rsp_data_s  = rsp_data_r;
`else
  assign rsp_valid_s = tag_valid_r & rst_n;
  assign rsp_owner_s = tag_owner_r;
  assign rsp_data_s  = ram_dout;
`endif

  // Route the response to its owner; data reads zero when not valid
  always_comb begin
    a_rsp_valid = 1'b0;
    b_rsp_valid = 1'b0;
    a_rsp_data  = 8'h00;
    b_rsp_data  = 8'h00;
    if (rsp_valid_s && (rsp_owner_s == OWNER_A)) begin
      a_rsp_valid = 1'b1;
      a_rsp_data  = rsp_data_s;
    end else if (rsp_valid_s && (rsp_owner_s == OWNER_B)) begin
      b_rsp_valid = 1'b1;
      b_rsp_data  = rsp_data_s;
    end else begin
      a_rsp_valid = 1'b0;
      b_rsp_valid = 1'b0;
    end
  end

endmodule
